imem_stream_encoder: RTL and testbench
======================================

Name: imem_stream_encoder

Overview:
- Write-side counterpart to the control decoder: accepts instruction fields (format, opcode, rs/rt/rd, funct, immediate, jump target) over a valid/ready stream.
- Packs the fields into 32-bit instruction words in the codebase's encoding and writes them sequentially into instruction memory.
- Holds the core (cpu_hold) while a program is loaded, then reports completion, the word count and any error.
- Sits between the testbench/host loader and the imem write port.

Parameters:
- ADDR_W, 6, imem word-address width. Memory depth is 2^ADDR_W words.
- BASE_ADDR, 0, first word address written after start. Capacity is 2^ADDR_W - BASE_ADDR words.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin a load; sampled only in IDLE.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept.
- in_fmt  in  2  encoding format: 0=R, 1=I, 2=J, 3=reserved.
- in_opcode  in  6  opcode (`OPCODE_* values from asm.vh).
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_funct  in  4  ALU funct (`FUNCT_*), R-format only.
- in_imm  in  16  immediate, I-format only.
- in_target  in  26  jump target, J-format only.
- in_last  in  1  marks the final word of the program.
- imem_we  out  1  imem write strobe.
- imem_addr  out  ADDR_W  imem word address.
- imem_wdata  out  32  encoded instruction.
- cpu_hold  out  1  keeps the core stalled/reset during a load.
- done  out  1  one-cycle pulse when a load completes successfully.
- err  out  1  sticky error flag: overflow or reserved format.
- words_written  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; imem_we, imem_addr, imem_wdata, cpu_hold, done, err, words_written all 0. Applies immediately, including mid-load; a partial program is left in imem.
- States:
  - IDLE: in_ready=0. On start=1, go to LOAD; cpu_hold<=1, err<=0, words_written<=0, write pointer<=BASE_ADDR.
  - LOAD: in_ready=1 while words_written < capacity, else 0.
  - DRAIN: in_ready=0; cpu_hold=1. One cycle later, go to IDLE with done<=1 for one cycle if err=0, and cpu_hold<=0 (cleared even if err=1).
  - ERR: in_ready=0; cpu_hold=1; err=1. Exits only to LOAD on start=1 (start is also sampled in ERR). This restarts from BASE_ADDR and clears err.
- Accept rule: a handshake occurs on the edge where in_valid & in_ready = 1.
  - At that edge: imem_we<=1, imem_addr<=pointer, imem_wdata<=encoded word; pointer and words_written increment.
  - Write latency is 1 cycle: the write is visible in the cycle after acceptance.
  - imem_we<=0 on every edge with no handshake.
  - Back-to-back acceptance sustains one word per cycle.
- Encoding, with all unused bits zero:
  - R: {opcode, rs, rt, rd, 7'b0, funct}.
  - I: {opcode, rs, rt, imm}.
  - J: {opcode, target}.
  - Reserved fmt=3: the word is written as 32'h0000_0000 and err<=1 (sticky); the load continues.
- in_last accepted: go to DRAIN. The last write is issued in DRAIN's cycle.
- Capacity reached without in_last: remain in LOAD with in_ready=0. If in_valid=1 is then seen, err<=1 and go to ERR; no write occurs and the pointer is not wrapped.
- in_last on the word that fills capacity exactly: normal DRAIN, no error.
- start asserted outside IDLE/ERR: ignored.
- Field values are taken only at the handshake edge. Inputs changing while in_ready=0 have no effect.
- done and imem_we are never high with rst_n=0.

Test Plan:
- R-encode: start; one bundle fmt=0, opcode=6'h00, rs=1, rt=2, rd=3, funct=4'h2, last=1.
  - Next cycle: imem_we=1, addr=0, wdata=32'h0022_1802.
  - Then done pulses 1 cycle, cpu_hold falls, words_written=1.
- I/J stream: I (opcode=6'h09, rt=5, imm=16'hFFFF), then J (opcode=6'h02, target=26'h10, last), back-to-back.
  - Writes on consecutive cycles: addr0=32'h2405_FFFF, addr1=32'h0800_0010.
  - in_valid=1 and in_ready=1 on both cycles.
- Backpressure/idle gaps: in_valid toggles 1,0,0,1 with last on the 2nd word.
  - Exactly 2 writes at addr 0,1; imem_we=0 during gaps.
  - Fields changed during gaps are not written.
- Overflow (ADDR_W=2, BASE_ADDR=0): 4 words without last, then in_valid=1.
  - in_ready=0 after the 4th accept; err=1, state ERR, cpu_hold=1, no 5th write.
  - A new start then clears err and rewrites from addr 0.
- Reserved format: fmt=3 as word 2 of a 3-word load.
  - addr2=32'h0; err=1 persists through DRAIN.
  - No done pulse; cpu_hold falls.
- Async reset mid-load: rst_n=0 between clock edges after 3 accepts.
  - All outputs are 0 immediately; state IDLE; in_ready=0.
  - After release, a start reloads from BASE_ADDR.

Source files
------------

// File: rtl/imem_stream_encoder.sv
// imem_stream_encoder
// Accepts instruction field bundles over a valid/ready stream, packs each into
// a 32-bit instruction word and writes it sequentially into instruction memory
// starting at BASE_ADDR. The core is held via cpu_hold while a load is active.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; core released
// LOAD  | accepting bundles; in_ready while capacity remains
// DRAIN | last word being written; completes on the next edge
// ERR   | overflow seen; core held until a new start restarts the load
module imem_stream_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [3:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_written
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CAP      = (ADDR_W+1)'(DEPTH - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic              can_accept;
    logic              accept;
    logic              overflow;
    logic              restart;
    logic [31:0]       enc_word;
    logic              enc_bad;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and overflow detection
    always_comb begin
        state_next = state;
        can_accept = 1'b0;
        accept     = 1'b0;
        overflow   = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    restart    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                can_accept = (words_written < CAP);
                accept     = in_valid & can_accept;
                overflow   = in_valid & ~can_accept;
                if (accept && in_last) begin
                    state_next = DRAIN;
                end else if (overflow) begin
                    state_next = ERR;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            ERR: begin
                if (start) begin
                    restart    = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready = can_accept;

    // Field packing; reserved format produces an all-zero word and flags an error
    always_comb begin
        enc_word = 32'h0000_0000;
        enc_bad  = 1'b0;
        case (in_fmt)
            2'd0:    enc_word = {in_opcode, in_rs, in_rt, in_rd, 7'b0, in_funct};
            2'd1:    enc_word = {in_opcode, in_rs, in_rt, in_imm};
            2'd2:    enc_word = {in_opcode, in_target};
            default: enc_bad  = 1'b1;
        endcase
    end

    // Write port, pointer, counters and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= 32'h0000_0000;
            cpu_hold      <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            words_written <= '0;
            ptr           <= '0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            if (restart) begin
                cpu_hold      <= 1'b1;
                err           <= 1'b0;
                words_written <= '0;
                ptr           <= BASE_PTR;
            end
            if (accept) begin
                imem_we       <= 1'b1;
                imem_addr     <= ptr;
                imem_wdata    <= enc_word;
                ptr           <= ptr + 1'b1;
                words_written <= words_written + 1'b1;
                if (enc_bad) begin
                    err <= 1'b1;
                end
            end
            if (overflow) begin
                err <= 1'b1;
            end
            if (state == DRAIN) begin
                cpu_hold <= 1'b0;
                done     <= ~err;
            end
        end
    end

endmodule

// File: tb/tb_imem_stream_encoder.sv
// Directed testbench for imem_stream_encoder. A default-sized instance covers
// encoding, streaming, gaps, reserved format and async reset; a 4-word
// instance covers capacity overflow and restart.
module tb_imem_stream_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [1:0]  in_fmt;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [3:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    logic        in_ready, imem_we, cpu_hold, done, err;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  words_written;

    logic        s_in_ready, s_imem_we, s_cpu_hold, s_done, s_err;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic [2:0]  s_words_written;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imem_stream_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err),
        .words_written(words_written)
    );

    imem_stream_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .in_last(in_last),
        .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .cpu_hold(s_cpu_hold), .done(s_done), .err(s_err),
        .words_written(s_words_written)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] fmt, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [3:0] fn, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic last);
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_opcode = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_funct  = fn;
        in_imm    = imm;
        in_target = tgt;
        in_last   = last;
    endtask

    task automatic gap();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        put(2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 4'h0, 16'h0, 26'h0, 1'b0);
        gap();
        tick();
        tick();
        chk("rst_we",    32'(imem_we), 32'd0);
        chk("rst_addr",  32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_hold",  32'(cpu_hold), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_ww",    32'(words_written), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // R-format single-word load
        do_start();
        chk("r_hold", 32'(cpu_hold), 32'd1);
        put(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 4'h2, 16'h0, 26'h0, 1'b1);
        chk("r_ready", 32'(in_ready), 32'd1);
        tick();
        gap();
        chk("r_we",    32'(imem_we), 32'd1);
        chk("r_addr",  32'(imem_addr), 32'd0);
        chk("r_wdata", imem_wdata, 32'h0022_1802);
        chk("r_drain_ready", 32'(in_ready), 32'd0);
        chk("r_drain_done",  32'(done), 32'd0);
        tick();
        chk("r_done",  32'(done), 32'd1);
        chk("r_hold0", 32'(cpu_hold), 32'd0);
        chk("r_ww",    32'(words_written), 32'd1);
        chk("r_we0",   32'(imem_we), 32'd0);
        tick();
        chk("r_done_pulse", 32'(done), 32'd0);

        // I then J back-to-back
        do_start();
        put(2'd1, 6'h09, 5'd0, 5'd5, 5'd0, 4'h0, 16'hFFFF, 26'h0, 1'b0);
        chk("ij_ready0", 32'(in_ready), 32'd1);
        tick();
        chk("ij_we0",    32'(imem_we), 32'd1);
        chk("ij_addr0",  32'(imem_addr), 32'd0);
        chk("ij_wdata0", imem_wdata, 32'h2405_FFFF);
        put(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 4'h0, 16'h0, 26'h10, 1'b1);
        chk("ij_ready1", 32'(in_ready), 32'd1);
        tick();
        gap();
        chk("ij_we1",    32'(imem_we), 32'd1);
        chk("ij_addr1",  32'(imem_addr), 32'd1);
        chk("ij_wdata1", imem_wdata, 32'h0800_0010);
        tick();
        chk("ij_done", 32'(done), 32'd1);
        chk("ij_ww",   32'(words_written), 32'd2);

        // Gaps between words; fields changed while idle must not be written
        do_start();
        put(2'd1, 6'h08, 5'd3, 5'd4, 5'd0, 4'h0, 16'h1234, 26'h0, 1'b0);
        tick();
        chk("gap_we0",    32'(imem_we), 32'd1);
        chk("gap_addr0",  32'(imem_addr), 32'd0);
        chk("gap_wdata0", imem_wdata, 32'h2064_1234);
        put(2'd0, 6'h3F, 5'd31, 5'd31, 5'd31, 4'hF, 16'hAAAA, 26'h155_5555, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("gap_we_idle1", 32'(imem_we), 32'd0);
        tick();
        chk("gap_we_idle2", 32'(imem_we), 32'd0);
        chk("gap_ww_idle",  32'(words_written), 32'd1);
        put(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 4'h0, 16'h0, 26'h3FF_FFFF, 1'b1);
        tick();
        gap();
        chk("gap_we1",    32'(imem_we), 32'd1);
        chk("gap_addr1",  32'(imem_addr), 32'd1);
        chk("gap_wdata1", imem_wdata, 32'h0FFF_FFFF);
        tick();
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_ww",   32'(words_written), 32'd2);

        // Reserved format as the third word (address 2)
        do_start();
        put(2'd1, 6'h08, 5'd3, 5'd4, 5'd0, 4'h0, 16'h1234, 26'h0, 1'b0);
        tick();
        put(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 4'h0, 16'h0, 26'h3FF_FFFF, 1'b0);
        tick();
        chk("res_err_before", 32'(err), 32'd0);
        put(2'd3, 6'h3F, 5'd7, 5'd7, 5'd7, 4'hF, 16'hFFFF, 26'h3FF_FFFF, 1'b1);
        tick();
        gap();
        chk("res_we",    32'(imem_we), 32'd1);
        chk("res_addr",  32'(imem_addr), 32'd2);
        chk("res_wdata", imem_wdata, 32'h0000_0000);
        chk("res_err",   32'(err), 32'd1);
        chk("res_hold",  32'(cpu_hold), 32'd1);
        tick();
        chk("res_no_done", 32'(done), 32'd0);
        chk("res_hold0",   32'(cpu_hold), 32'd0);
        chk("res_err_sticky", 32'(err), 32'd1);
        chk("res_ww",      32'(words_written), 32'd3);

        // Async reset mid-load after three accepts
        do_start();
        put(2'd1, 6'h01, 5'd1, 5'd1, 5'd0, 4'h0, 16'h0001, 26'h0, 1'b0);
        tick();
        tick();
        tick();
        chk("ar_we_pre", 32'(imem_we), 32'd1);
        chk("ar_ww_pre", 32'(words_written), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we",    32'(imem_we), 32'd0);
        chk("ar_addr",  32'(imem_addr), 32'd0);
        chk("ar_wdata", imem_wdata, 32'd0);
        chk("ar_hold",  32'(cpu_hold), 32'd0);
        chk("ar_err",   32'(err), 32'd0);
        chk("ar_ww",    32'(words_written), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd0);
        gap();
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        put(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 4'h0, 16'h0, 26'h20, 1'b1);
        tick();
        gap();
        chk("ar_re_addr",  32'(imem_addr), 32'd0);
        chk("ar_re_wdata", imem_wdata, 32'h0800_0020);
        tick();
        chk("ar_re_done", 32'(done), 32'd1);
        chk("ar_re_ww",   32'(words_written), 32'd1);

        // Overflow on the 4-word instance
        do_start();
        for (int i = 0; i < 4; i++) begin
            put(2'd1, 6'h09, 5'd0, 5'd1, 5'd0, 4'h0, 16'(i), 26'h0, 1'b0);
            chk($sformatf("ov_ready%0d", i), 32'(s_in_ready), 32'd1);
            tick();
            chk($sformatf("ov_addr%0d", i), 32'(s_imem_addr), 32'(i));
            chk($sformatf("ov_wdata%0d", i), s_imem_wdata, 32'h2401_0000 | 32'(i));
        end
        chk("ov_ready_full", 32'(s_in_ready), 32'd0);
        chk("ov_ww_full",    32'(s_words_written), 32'd4);
        tick();
        chk("ov_err",   32'(s_err), 32'd1);
        chk("ov_no_we", 32'(s_imem_we), 32'd0);
        chk("ov_hold",  32'(s_cpu_hold), 32'd1);
        chk("ov_ww",    32'(s_words_written), 32'd4);
        tick();
        chk("ov_err_hold",  32'(s_err), 32'd1);
        chk("ov_ready_err", 32'(s_in_ready), 32'd0);
        chk("ov_no_we2",    32'(s_imem_we), 32'd0);
        gap();
        do_start();
        chk("ov_err_clr",  32'(s_err), 32'd0);
        chk("ov_ww_clr",   32'(s_words_written), 32'd0);
        chk("ov_ready_re", 32'(s_in_ready), 32'd1);
        put(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 4'h0, 16'h0, 26'h5, 1'b1);
        tick();
        gap();
        chk("ov_re_we",    32'(s_imem_we), 32'd1);
        chk("ov_re_addr",  32'(s_imem_addr), 32'd0);
        chk("ov_re_wdata", s_imem_wdata, 32'h0800_0005);
        tick();
        chk("ov_re_done", 32'(s_done), 32'd1);
        chk("ov_re_hold", 32'(s_cpu_hold), 32'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
